// File: rtl/fft_spectrum_capture.sv
// Captures FFT output frames and keeps saturated magnitudes of the lower half-spectrum
// in a ping-pong buffer: the back bank fills while the display reads the front bank.
module fft_spectrum_capture #(
  parameter int unsigned N          = 1024,
  parameter int unsigned data_width = 24,
  parameter int unsigned mag_width  = 9,
  parameter int unsigned mag_shift  = 12
) (
  input  logic                         clk,
  input  logic                         rst_n,
  input  logic                         capture_en,
  input  logic                         source_valid,
  input  logic                         source_sop,
  input  logic                         source_eop,
  input  logic signed [data_width-1:0] source_real,
  input  logic signed [data_width-1:0] source_imag,
  output logic                         source_ready,
  input  logic [$clog2(N/2)-1:0]       rd_addr,
  output logic [mag_width-1:0]         rd_data,
  output logic                         frame_ready,
  output logic                         frame_error,
  output logic                         cap_idle,
  output logic                         cap_active
);

  localparam int unsigned addr_w  = $clog2(N/2);
  localparam int unsigned idx_w   = $clog2(N);
  localparam int unsigned m_w     = data_width + 1;
  localparam int unsigned mag_max = (2 ** mag_width) - 1;

  typedef enum logic {IDLE, CAPTURE} state_t;

  state_t                  state, state_d;
  logic [idx_w-1:0]        k, k_d;
  logic                    accept;
  logic                    beat_we_c, done_c, err_c;
  logic [addr_w-1:0]       beat_idx_c;
  logic [data_width-1:0]   abs_re_c, abs_im_c;

  logic                    s1_we, s1_done, s1_err;
  logic [addr_w-1:0]       s1_idx;
  logic [data_width-1:0]   s1_a, s1_b;
  logic                    s2_done, s2_err;
  logic                    bank_sel, sel_next_c;

  logic [data_width-1:0]   mx_c, mn_c;
  logic [m_w-1:0]          m_c, sh_c;
  logic [mag_width-1:0]    mag_c;

  logic [mag_width-1:0]    mem [N];

  assign accept = source_valid && source_ready;

  // Absolute values; the most negative input maps to 2^(data_width-1) as unsigned.
  assign abs_re_c = source_real[data_width-1] ? data_width'(-source_real) : data_width'(source_real);
  assign abs_im_c = source_imag[data_width-1] ? data_width'(-source_imag) : data_width'(source_imag);

  // Framing FSM: next state, beat index and per-beat framing verdict.
  always_comb begin
    state_d    = state;
    k_d        = k;
    beat_we_c  = 1'b0;
    beat_idx_c = '0;
    done_c     = 1'b0;
    err_c      = 1'b0;
    case (state)
      IDLE: begin
        if (accept && source_sop && capture_en) begin
          if (source_eop) begin
            err_c = 1'b1;
          end else begin
            state_d   = CAPTURE;
            k_d       = idx_w'(1);
            beat_we_c = 1'b1;
          end
        end
      end
      CAPTURE: begin
        if (accept) begin
          beat_idx_c = addr_w'(k);
          beat_we_c  = (k < idx_w'(N/2));
          if (source_eop && (k == idx_w'(N-1))) begin
            done_c  = 1'b1;
            state_d = IDLE;
            k_d     = '0;
          end else if (source_eop || source_sop || (k == idx_w'(N-1))) begin
            err_c   = 1'b1;
            state_d = IDLE;
            k_d     = '0;
          end else begin
            k_d = k + idx_w'(1);
          end
        end
      end
      default: state_d = IDLE;
    endcase
  end

  // FSM state, beat counter and registered state flags.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state      <= IDLE;
      k          <= '0;
      cap_idle   <= 1'b1;
      cap_active <= 1'b0;
    end else begin
      state      <= state_d;
      k          <= k_d;
      cap_idle   <= (state_d == IDLE);
      cap_active <= (state_d == CAPTURE);
    end
  end

  // Stage-2 magnitude: max + min/2, shifted and saturated.
  always_comb begin
    mx_c  = (s1_a >= s1_b) ? s1_a : s1_b;
    mn_c  = (s1_a >= s1_b) ? s1_b : s1_a;
    m_c   = m_w'(mx_c) + m_w'(mn_c >> 1);
    sh_c  = m_c >> mag_shift;
    mag_c = (sh_c > m_w'(mag_max)) ? mag_width'(mag_max) : mag_width'(sh_c);
  end

  // Front bank after this edge; a swap edge already reads and writes relative to the new front.
  assign sel_next_c = bank_sel ^ s2_done;

  // Pipeline, bank select, pulses and display read port.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      source_ready <= 1'b0;
      s1_we        <= 1'b0;
      s1_idx       <= '0;
      s1_a         <= '0;
      s1_b         <= '0;
      s1_done      <= 1'b0;
      s1_err       <= 1'b0;
      s2_done      <= 1'b0;
      s2_err       <= 1'b0;
      bank_sel     <= 1'b0;
      frame_ready  <= 1'b0;
      frame_error  <= 1'b0;
      rd_data      <= '0;
    end else begin
      source_ready <= 1'b1;
      s1_we        <= beat_we_c;
      s1_idx       <= beat_idx_c;
      s1_a         <= abs_re_c;
      s1_b         <= abs_im_c;
      s1_done      <= done_c;
      s1_err       <= err_c;
      s2_done      <= s1_done;
      s2_err       <= s1_err;
      bank_sel     <= sel_next_c;
      frame_ready  <= s2_done;
      frame_error  <= s2_err;
      rd_data      <= mem[{sel_next_c, rd_addr}];
    end
  end

  // Back-bank write; memory contents survive reset.
  always_ff @(posedge clk) begin
    if (s1_we) begin
      mem[{~sel_next_c, s1_idx}] <= mag_c;
    end
  end

endmodule
